// File: rtl/btn_conditioner.sv
// Four-lane push-button conditioner: synchronise, debounce, detect press, hold as a pending request.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat events on every lane.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       shield_ready,
    input  logic [3:0] btn,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right
);

    localparam bit CFG_OK = (DEBOUNCE_CYCLES >= 2) && (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);
`endif

    logic [3:0] pending;

    if (CFG_OK) begin : g_cfg_ok
        for (genvar i = 0; i < 4; i++) begin : g_lane
            logic             s1;
            logic             s2;
            logic             stable;
            logic [CNT_W-1:0] dbc_cnt;
            logic             settle;
            logic             press;
            logic             event_fire;
            logic             pend;

            // NOTE: the synchroniser flops are reset too, so a press in flight at reset is
            // discarded and a button still held afterwards goes through the full debounce.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1 <= 1'b0;
                    s2 <= 1'b0;
                end else begin
                    s1 <= btn[i];
                    s2 <= s1;
                end
            end

            assign settle = (s2 != stable) && (dbc_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
            assign press  = settle && s2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stable  <= 1'b0;
                    dbc_cnt <= '0;
                end else if (s2 == stable) begin
                    dbc_cnt <= '0;
                end else if (settle) begin
                    stable  <= s2;
                    dbc_cnt <= '0;
                end else begin
                    dbc_cnt <= dbc_cnt + CNT_W'(1);
                end
            end

`ifdef BTN_AUTOREPEAT_EN
            logic [RPT_W-1:0] rpt_cnt;
            logic             rpt_armed;
            logic             rpt_hit;

            // rpt_armed separates the long initial delay from the shorter steady period.
            assign rpt_hit = stable && (rpt_armed ? (rpt_cnt == RPT_W'(REPEAT_PERIOD - 1))
                                                  : (rpt_cnt == RPT_W'(REPEAT_DELAY - 1)));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rpt_cnt   <= '0;
                    rpt_armed <= 1'b0;
                end else if (!stable) begin
                    rpt_cnt   <= '0;
                    rpt_armed <= 1'b0;
                end else if (rpt_hit) begin
                    rpt_cnt   <= '0;
                    rpt_armed <= 1'b1;
                end else begin
                    rpt_cnt <= rpt_cnt + RPT_W'(1);
                end
            end

            assign event_fire = press | rpt_hit;
`else
            assign event_fire = press;
`endif

            // A fresh event outranks a same-edge consumption so no press is ever lost.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend <= 1'b0;
                end else if (event_fire) begin
                    pend <= 1'b1;
                end else if (shield_ready) begin
                    pend <= 1'b0;
                end
            end

            assign pending[i] = pend;
        end
    end else begin : g_cfg_bad
        // An illegal parameter set keeps all requests quiet.
        assign pending = '0;
    end

    assign up    = pending[0];
    assign down  = pending[1];
    assign left  = pending[2];
    assign right = pending[3];

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner against a cycle-level reference model of the button rules.
// Build with BTN_AUTOREPEAT_EN defined to also exercise the auto-repeat scenario.
`timescale 1ns/1ps
module tb_btn_conditioner;

    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 20;
    localparam int unsigned RP  = 8;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       shield_ready = 1'b0;
    logic [3:0] btn          = 4'b0000;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [3:0] outs;

    int n_cmp = 0;
    int n_err = 0;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .shield_ready(shield_ready),
        .btn         (btn),
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right)
    );

    always #5 clk = ~clk;

    assign outs = {right, left, down, up};

    // Reference model: a button level counts once it has disagreed with the accepted
    // level for DEB consecutive edges, seen two edges late through the synchroniser.
    logic [3:0] m_pend;
    logic [3:0] m_stable;
    logic [3:0] m_d1;
    logic [3:0] m_d2;
    int         m_streak [4];
    longint     m_edge;
`ifdef BTN_AUTOREPEAT_EN
    longint     m_press [4];
`endif

    task automatic model_clear();
        m_pend   = '0;
        m_stable = '0;
        m_d1     = '0;
        m_d2     = '0;
        m_edge   = 0;
        for (int i = 0; i < 4; i++) begin
            m_streak[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
            m_press[i] = 0;
`endif
        end
    endtask

    task automatic model_step();
        logic [3:0] seen;
        logic       ev;
`ifdef BTN_AUTOREPEAT_EN
        longint     age;
`endif
        seen = m_d2;
        for (int i = 0; i < 4; i++) begin
            ev = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            if (m_stable[i]) begin
                age = m_edge - m_press[i];
                if (age == longint'(RD) || (age > longint'(RD) && ((age - longint'(RD)) % longint'(RP)) == 0))
                    ev = 1'b1;
            end
`endif
            if (seen[i] != m_stable[i]) begin
                m_streak[i]++;
                if (m_streak[i] == int'(DEB)) begin
                    m_stable[i] = seen[i];
                    m_streak[i] = 0;
                    if (seen[i]) begin
                        ev = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        m_press[i] = m_edge;
`endif
                    end
                end
            end else begin
                m_streak[i] = 0;
            end
            if (ev)
                m_pend[i] = 1'b1;
            else if (shield_ready)
                m_pend[i] = 1'b0;
        end
        m_d2 = m_d1;
        m_d1 = btn;
        m_edge++;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n)
                model_clear();
            else
                model_step();
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic flush();
        btn          = 4'b0000;
        shield_ready = 1'b0;
        tick(8);
        shield_ready = 1'b1;
        tick(1);
        shield_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        btn          = 4'b1111;
        shield_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (outs !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold: got %b expected %b", outs, 4'b0000);
        end
        btn = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick(8);
        n_cmp++;
        if (outs !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_idle: got %b expected %b", outs, 4'b0000);
        end
    endtask

    task automatic test_press_hold();
        logic [3:0] exp;
        btn          = 4'b0001;
        shield_ready = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            tick(1);
            exp = (k >= int'(DEB) + 1) ? 4'b0001 : 4'b0000;
            n_cmp++;
            if (outs !== exp) begin
                n_err++;
                $display("FAIL press_latency edge %0d: got %b expected %b", k, outs, exp);
            end
        end
        shield_ready = 1'b1;
        tick(1);
        shield_ready = 1'b0;
        n_cmp++;
        if (outs !== 4'b0000) begin
            n_err++;
            $display("FAIL consume: got %b expected %b", outs, 4'b0000);
        end
        for (int k = 0; k < 30; k++) begin
            tick(1);
            n_cmp++;
            if (outs !== m_pend) begin
                n_err++;
                $display("FAIL hold_model cycle %0d: got %b expected %b", k, outs, m_pend);
            end
`ifndef BTN_AUTOREPEAT_EN
            n_cmp++;
            if (outs !== 4'b0000) begin
                n_err++;
                $display("FAIL hold_no_repeat cycle %0d: got %b expected %b", k, outs, 4'b0000);
            end
`endif
        end
        flush();
    endtask

    task automatic test_glitch();
        logic [3:0] exp;
        for (int k = 0; k < 14; k++) begin
            btn = (k < 3) ? 4'b0100 : 4'b0000;
            tick(1);
            n_cmp++;
            if (outs !== 4'b0000) begin
                n_err++;
                $display("FAIL glitch_3 edge %0d: got %b expected %b", k, outs, 4'b0000);
            end
        end
        for (int k = 0; k < 14; k++) begin
            btn = (k < int'(DEB)) ? 4'b0100 : 4'b0000;
            tick(1);
            exp = (k >= int'(DEB) + 1) ? 4'b0100 : 4'b0000;
            n_cmp++;
            if (outs !== exp) begin
                n_err++;
                $display("FAIL glitch_4 edge %0d: got %b expected %b", k, outs, exp);
            end
        end
        shield_ready = 1'b1;
        tick(1);
        shield_ready = 1'b0;
        tick(10);
        n_cmp++;
        if (outs !== 4'b0000) begin
            n_err++;
            $display("FAIL glitch_once: got %b expected %b", outs, 4'b0000);
        end
        flush();
    endtask

    task automatic test_back_to_back();
        btn = 4'b1000;
        tick(6);
        n_cmp++;
        if (outs !== 4'b1000) begin
            n_err++;
            $display("FAIL b2b_first: got %b expected %b", outs, 4'b1000);
        end
        btn = 4'b0000;
        tick(8);
        btn = 4'b1000;
        tick(int'(DEB) + 1);
        shield_ready = 1'b1;
        tick(1);
        shield_ready = 1'b0;
        n_cmp++;
        if (outs !== 4'b1000) begin
            n_err++;
            $display("FAIL b2b_event_wins: got %b expected %b", outs, 4'b1000);
        end
        btn = 4'b0000;
        tick(8);
        btn = 4'b1000;
        tick(8);
        n_cmp++;
        if (outs !== 4'b1000) begin
            n_err++;
            $display("FAIL b2b_merged: got %b expected %b", outs, 4'b1000);
        end
        shield_ready = 1'b1;
        tick(1);
        shield_ready = 1'b0;
        n_cmp++;
        if (outs !== 4'b0000) begin
            n_err++;
            $display("FAIL b2b_single_consume: got %b expected %b", outs, 4'b0000);
        end
        flush();
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp;
        btn = 4'b0010;
        tick(6);
        n_cmp++;
        if (outs !== 4'b0010) begin
            n_err++;
            $display("FAIL rst_mid_pending: got %b expected %b", outs, 4'b0010);
        end
        btn = 4'b0011;
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (outs !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_mid_async: got %b expected %b", outs, 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            tick(1);
            exp = (k >= int'(DEB) + 1) ? 4'b0011 : 4'b0000;
            n_cmp++;
            if (outs !== exp) begin
                n_err++;
                $display("FAIL rst_mid_repress edge %0d: got %b expected %b", k, outs, exp);
            end
        end
        flush();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
            shield_ready = ($urandom_range(0, 3) == 0);
            tick(1);
            n_cmp++;
            if (outs !== m_pend) begin
                n_err++;
                $display("FAIL random cycle %0d: got %b expected %b", c, outs, m_pend);
            end
        end
        flush();
    endtask

`ifdef BTN_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int got [4];
        int exp [4];
        int found;
        int late;
        exp[0] = int'(DEB) + 1;
        exp[1] = exp[0] + int'(RD);
        exp[2] = exp[1] + int'(RP);
        exp[3] = exp[2] + int'(RP);
        for (int j = 0; j < 4; j++) got[j] = -1;
        found = 0;
        btn   = 4'b0001;
        for (int k = 0; k < 43; k++) begin
            tick(1);
            shield_ready = 1'b0;
            n_cmp++;
            if (outs !== m_pend) begin
                n_err++;
                $display("FAIL repeat_model edge %0d: got %b expected %b", k, outs, m_pend);
            end
            if (up === 1'b1) begin
                if (found < 4) got[found] = k;
                found++;
                shield_ready = 1'b1;
            end
        end
        n_cmp++;
        if (found !== 4) begin
            n_err++;
            $display("FAIL repeat_count: got %0d expected %0d", found, 4);
        end
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (got[j] !== exp[j]) begin
                n_err++;
                $display("FAIL repeat_edge %0d: got %0d expected %0d", j, got[j], exp[j]);
            end
        end
        btn          = 4'b0000;
        shield_ready = 1'b0;
        late         = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (up === 1'b1) late++;
        end
        n_cmp++;
        if (late !== 0) begin
            n_err++;
            $display("FAIL repeat_after_release: got %0d expected %0d", late, 0);
        end
        flush();
    endtask
`endif

    initial begin
        test_reset();
        test_press_hold();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef BTN_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
